// File: rtl/breg_bank.sv
// breg_bank: small register bank with per-entry ALU ops and bus drive.
// One entry is written per clock; zero/carry flags track the last write.
module breg_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] bus_in,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    wsel,
  input  logic [AW-1:0]    rsel,
  input  logic             eb,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_oe,
  output logic             zero,
  output logic             carry
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_ROTL = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] res;
  logic             cy;
  logic             wr;

  assign cur = regs[wsel];

  always_comb begin
    res = cur;
    cy  = carry;
    wr  = 1'b1;
    unique case (op)
      OP_HOLD: wr = 1'b0;
      OP_LOAD: res = bus_in;
      OP_INC: begin
        res = cur + ONE;
        cy  = &cur;
      end
      OP_DEC: begin
        res = cur - ONE;
        cy  = ~|cur;
      end
      OP_SHL: begin
        res = {cur[WIDTH-2:0], 1'b0};
        cy  = cur[WIDTH-1];
      end
      OP_SHR: begin
        res = {1'b0, cur[WIDTH-1:1]};
        cy  = cur[0];
      end
      OP_ROTL: begin
        res = {cur[WIDTH-2:0], cur[WIDTH-1]};
        cy  = cur[WIDTH-1];
      end
      OP_CLR: begin
        res = '0;
        cy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++)
        regs[i] <= '0;
      zero  <= 1'b0;
      carry <= 1'b0;
    end else if (wr) begin
      regs[wsel] <= res;
      zero       <= (res == '0);
      carry      <= cy;
    end
  end

  // Read path comes from stored state only, so a load of the
  // entry being driven onto the bus cannot form a loop.
  assign out     = regs[rsel];
  assign bus_oe  = eb;
  assign bus_out = eb ? regs[rsel] : '0;

endmodule

// File: tb/tb_breg_bank.sv
// tb_breg_bank: scoreboard bench for breg_bank.
// Default build plus 4x2 and 16x16 wrap checks.
module tb_breg_bank;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] bin = '0;
  logic [2:0] op = '0;
  logic [1:0] wsel = '0;
  logic [1:0] rsel = '0;
  logic       eb = 1'b0;
  logic [7:0] out, bus_out;
  logic       bus_oe, zero, carry;

  logic       clr4 = 1'b1;
  logic [3:0] bin4 = '0;
  logic [2:0] op4 = '0;
  logic       ws4 = 1'b0;
  logic       rs4 = 1'b0;
  logic [3:0] out4, bo4;
  logic       oe4, z4, c4;

  logic        clr16 = 1'b1;
  logic [15:0] bin16 = '0;
  logic [2:0]  op16 = '0;
  logic [3:0]  ws16 = '0;
  logic [3:0]  rs16 = '0;
  logic [15:0] out16, bo16;
  logic        oe16, z16, c16;

  always #5 clk = ~clk;

  breg_bank dut (
    .clk(clk), .clr(clr), .bus_in(bin), .op(op),
    .wsel(wsel), .rsel(rsel), .eb(eb), .out(out),
    .bus_out(bus_out), .bus_oe(bus_oe),
    .zero(zero), .carry(carry)
  );

  breg_bank #(.WIDTH(4), .DEPTH(2)) dut4 (
    .clk(clk), .clr(clr4), .bus_in(bin4), .op(op4),
    .wsel(ws4), .rsel(rs4), .eb(1'b1), .out(out4),
    .bus_out(bo4), .bus_oe(oe4),
    .zero(z4), .carry(c4)
  );

  breg_bank #(.WIDTH(16), .DEPTH(16)) dut16 (
    .clk(clk), .clr(clr16), .bus_in(bin16), .op(op16),
    .wsel(ws16), .rsel(rs16), .eb(1'b0), .out(out16),
    .bus_out(bo16), .bus_oe(oe16),
    .zero(z16), .carry(c16)
  );

  typedef struct {
    string      tag;
    logic [7:0] o;
    logic [7:0] bo;
    logic       z;
    logic       c;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] m [4];
  logic       mz = 1'b0;
  logic       mc = 1'b0;
  int         ncmp = 0;
  int         nbad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Reference update: carries taken from widened arithmetic.
  task automatic model(input logic [2:0] o, input int ws,
                       input logic [7:0] d, input logic c);
    logic [8:0] t;
    logic [7:0] v;
    if (c) begin
      foreach (m[i]) m[i] = '0;
      mz = 1'b0;
      mc = 1'b0;
      return;
    end
    if (o == 3'b000) return;
    v = m[ws];
    case (o)
      3'b001: t = {mc, d};
      3'b010: t = {1'b0, v} + 9'd1;
      3'b011: t = {1'b0, v} - 9'd1;
      3'b100: t = {v, 1'b0};
      3'b101: t = {v[0], 1'b0, v[7:1]};
      3'b110: t = {v[7], v[6:0], v[7]};
      default: t = '0;
    endcase
    m[ws] = t[7:0];
    mc = t[8];
    mz = (t[7:0] == 8'h00);
  endtask

  task automatic step(input string tag, input logic [2:0] o,
                      input int ws, input int rs,
                      input logic [7:0] d, input logic e,
                      input logic c);
    exp_t x;
    @(negedge clk);
    op = o; wsel = 2'(ws); rsel = 2'(rs);
    bin = d; eb = e; clr = c;
    #1;
    chk({tag, "_oe"}, bus_oe, e);
    chk({tag, "_pre"}, bus_out, e ? m[rs] : 8'h00);
    model(o, ws, d, c);
    x.tag = tag;
    x.o = m[rs];
    x.bo = e ? m[rs] : 8'h00;
    x.z = mz;
    x.c = mc;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, "_empty"}, 1, 0);
    end else begin
      x = sbq.pop_front();
      chk({x.tag, "_out"}, out, x.o);
      chk({x.tag, "_bus"}, bus_out, x.bo);
      chk({x.tag, "_z"}, zero, x.z);
      chk({x.tag, "_c"}, carry, x.c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want done");
    $fatal(1, "timeout");
  end

  initial begin
    foreach (m[i]) m[i] = 8'hxx;
    step("rst", 3'b000, 0, 0, 8'h00, 1'b0, 1'b1);
    chk("rst_out0", out, 8'h00);

    step("ld_a5", 3'b001, 2, 2, 8'hA5, 1'b0, 1'b0);
    chk("a5", out, 8'hA5);
    chk("a5_z", zero, 1'b0);
    step("r0", 3'b000, 0, 0, 8'h00, 1'b0, 1'b0);
    step("r1", 3'b000, 0, 1, 8'h00, 1'b0, 1'b0);
    step("r3", 3'b000, 0, 3, 8'h00, 1'b0, 1'b0);

    step("ld_ff", 3'b001, 1, 1, 8'hFF, 1'b0, 1'b0);
    step("inc_w", 3'b010, 1, 1, 8'h00, 1'b0, 1'b0);
    chk("incw_v", out, 8'h00);
    chk("incw_c", carry, 1'b1);
    chk("incw_z", zero, 1'b1);
    step("dec_b", 3'b011, 1, 1, 8'h00, 1'b0, 1'b0);
    chk("decb_v", out, 8'hFF);
    chk("decb_c", carry, 1'b1);

    step("ld_81", 3'b001, 0, 0, 8'h81, 1'b0, 1'b0);
    step("shl", 3'b100, 0, 0, 8'h00, 1'b0, 1'b0);
    chk("shl_v", out, 8'h02);
    step("shr", 3'b101, 0, 0, 8'h00, 1'b0, 1'b0);
    chk("shr_v", out, 8'h01);
    chk("shr_c", carry, 1'b0);
    step("ld_81b", 3'b001, 0, 0, 8'h81, 1'b0, 1'b0);
    chk("ld_keepc", carry, 1'b0);
    step("rotl", 3'b110, 0, 0, 8'h00, 1'b0, 1'b0);
    chk("rotl_v", out, 8'h03);
    chk("rotl_c", carry, 1'b1);
    step("clr_op", 3'b111, 0, 0, 8'h00, 1'b0, 1'b0);

    step("ld_3c", 3'b001, 3, 3, 8'h3C, 1'b0, 1'b0);
    step("bus_ld", 3'b001, 3, 3, 8'h55, 1'b1, 1'b0);
    chk("bus_new", bus_out, 8'h55);
    step("bus_off", 3'b000, 0, 3, 8'h00, 1'b0, 1'b0);
    chk("bus_zero", bus_out, 8'h00);

    step("dec0", 3'b011, 2, 2, 8'h00, 1'b0, 1'b0);
    step("clr_ld", 3'b001, 0, 0, 8'h77, 1'b1, 1'b1);
    chk("clrld_v", out, 8'h00);
    for (int i = 0; i < 4; i++)
      step("hold", 3'b000, 0, i, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 60; i++)
      step("rnd", 3'($urandom_range(0, 7)),
           $urandom_range(0, 3), $urandom_range(0, 3),
           8'($urandom), 1'($urandom), 1'($urandom_range(0, 15) == 0));

    @(negedge clk);
    clr4 = 1'b0; clr16 = 1'b0;
    op4 = 3'b001; ws4 = 1'b1; rs4 = 1'b1; bin4 = 4'hF;
    op16 = 3'b001; ws16 = 4'd9; rs16 = 4'd9; bin16 = 16'hFFFF;
    @(negedge clk);
    chk("w4_ld", out4, 4'hF);
    chk("w16_ld", out16, 16'hFFFF);
    op4 = 3'b010;
    op16 = 3'b010;
    @(posedge clk);
    #1;
    op4 = 3'b000;
    op16 = 3'b000;
    chk("w4_v", out4, 4'h0);
    chk("w4_c", c4, 1'b1);
    chk("w4_z", z4, 1'b1);
    chk("w4_oe", bo4, 4'h0);
    chk("w16_v", out16, 16'h0000);
    chk("w16_c", c16, 1'b1);
    chk("w16_z", z16, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
